aes_decrypt_control: RTL
========================

# aes_decrypt_control

Iterative AES-128 inverse-cipher controller, the decrypt-side counterpart of the CAN-SEC encrypt control path. It recovers a 128-bit plaintext block from a ciphertext block using the shared fixed CAN-SEC key, one inverse round per clock. It sits on the CAN-XL receive path between the frame buffer and the payload consumer.

## Interface
- KEY, 128'h2b7e151628aed2a6abf7158809cf4f3c, AES-128 cipher key; round 0 key.
- clk  in  1  system clock; all logic is on the rising edge.
- g_rst_n  in  1  reset, synchronous, active-low.
- start  in  1  decrypt request; sampled only in IDLE.
- cipher_in  in  128  ciphertext block, byte 0 in [127:120], column-major; latched on an accepted start.
- tx_success  in  1  frame-complete clear (TX side).
- rx_success  in  1  frame-complete clear (RX side).
- plain_out  out  128  decrypted block, registered; holds until the next done or a clear.
- done  out  1  one-cycle pulse, coincident with the plain_out update.
- busy  out  1  high in every state except IDLE.

## Operation
- Registers:
  - state[127:0].
  - Round-key cache rk[0..10], each 128 bits.
  - cache_valid.
  - Round counter rnd[3:0].
  - FSM: IDLE, KEYGEN, INIT, ROUND, FINAL.
- S-box lookups use shared word modules, which are not part of this block:
  - existing forward Subytes: 1 instance, for the key schedule.
  - inv_subytes: 4 instances, covering all 16 bytes.
- IDLE:
  - On start=1, latch cipher_in into state.
  - If cache_valid=0, go to KEYGEN with rnd=1; otherwise go to INIT.
  - rk[0]=KEY is always present.
- KEYGEN, for rnd=1..10, one key per cycle:
  - rk[rnd] = standard AES-128 expansion of rk[rnd-1] (RotWord, SubWord, Rcon).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 in the MSB.
  - After rnd=10: set cache_valid=1 and go to INIT.
- INIT: state ^= rk[10]; rnd=9; go to ROUND.
- ROUND, one cycle per round:
  - state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]).
  - Decrement rnd; after rnd=1 go to FINAL.
- FINAL:
  - plain_out = InvSubBytes(InvShiftRows(state)) ^ rk[0].
  - done=1; go to IDLE.
- InvShiftRows: row r rotates right by r bytes.
- InvMixColumns: GF(2^8) coefficients 0e,0b,0d,09; reduction polynomial 0x11b.
- Clear (tx_success | rx_success) on any cycle:
  - plain_out=0 and done=0.
  - FSM returns to IDLE, aborting any decrypt in progress.
  - The cache and cache_valid are retained.
  - Clear has priority over start and over FINAL in the same cycle.
- start while busy is ignored; it is neither queued nor latched.
- A cipher_in change after acceptance has no effect.

## Timing
- Reset values:
  - plain_out=0, done=0, busy=0.
  - FSM=IDLE, cache_valid=0, rnd=0.
  - state=0, rk[1..10]=0.
- A reset asserted mid-operation takes effect at the next edge. The FSM returns to IDLE and the cache is invalidated.
- Latency is counted from the start-sampling edge E0 to the edge that registers plain_out/done:
  - cold (cache_valid=0): 21 cycles — KEYGEN E1–E10, INIT E11, ROUND E12–E20, FINAL E21.
  - warm: 11 cycles — INIT E1, ROUND E2–E10, FINAL E11.
- busy rises after E0 and falls after the FINAL edge.
- A start on the cycle after done is accepted, so back-to-back warm throughput is one block per 12 cycles.
- done lasts exactly one cycle unless a clear occurs in that cycle; the clear forces done=0.

## Test plan
- Cold decrypt: reset, start with cipher_in=3925841d02dc09fbdc118597196a0b32 and KEY default.
  - Required: done at exactly E21 with plain_out=3243f6a8885a308d313198a2e0370734.
  - Required: rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Warm back-to-back: a second start on the cycle after done with the same cipher.
  - Required: done 11 cycles after start, same plaintext.
  - Required: busy low for exactly one cycle between the two decrypts.
- Abort: rx_success pulsed at E15 of a cold decrypt.
  - Required: IDLE next cycle, plain_out=0, no done.
  - Required: a following start completes warm in 11 cycles with the correct plaintext.
- Ignored start and input change: pulse start and change cipher_in to all-ones during ROUND.
  - Required: the original plaintext is unaffected; only one done is produced.
- Reset mid-KEYGEN at E5: g_rst_n=0 for one cycle.
  - Required: all outputs 0.
  - Required: the next start takes the full 21-cycle cold path.
- Clear/start collision: tx_success and start in the same IDLE cycle.
  - Required: busy stays 0 and plain_out=0.

Source files
------------

// File: rtl/aes_decrypt_control.sv
// aes_decrypt_control: iterative AES-128 inverse cipher, one inverse round per clock,
// with a lazily filled round-key cache that survives frame clears but not reset.
module aes_decrypt_control (
    input  logic         clk,
    input  logic         g_rst_n,
    input  logic         start,
    input  logic [127:0] cipher_in,
    input  logic         tx_success,
    input  logic         rx_success,
    output logic [127:0] plain_out,
    output logic         done,
    output logic         busy
);
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef enum logic [2:0] {IDLE, KEYGEN, INIT, ROUND, FINAL} fsm_t;

    fsm_t         fsm, fsm_nxt;
    logic [127:0] state;
    logic [127:0] rk_reg [1:10];
    logic [127:0] rk [0:10];
    logic         cache_valid;
    logic [3:0]   rnd;
    logic         clr;
    logic [127:0] round_out, final_out, key_nxt;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  cf;
        logic [7:0]   b;
        cf = 32'h0e0b0d09;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++)
                    b = b ^ gmul(cf[31-8*((k-r+4)%4) -: 8], s[127-8*(k+4*c) -: 8]);
                o[127-8*(r+4*c) -: 8] = b;
            end
        return o;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign clr  = tx_success | rx_success;
    assign busy = fsm != IDLE;

    always_comb begin
        rk[0] = KEY;
        for (int i = 1; i <= 10; i++) rk[i] = rk_reg[i];
        key_nxt   = expand(rk[rnd-4'd1], rnd == 4'd9 ? 8'h1b : rnd == 4'd10 ? 8'h36 : 8'h01 << (rnd - 4'd1));
        round_out = inv_mix(inv_shift_sub(state) ^ rk[rnd]);
        final_out = inv_shift_sub(state) ^ KEY;
    end

    always_ff @(posedge clk)
        fsm <= !g_rst_n ? IDLE : fsm_nxt;

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (start) fsm_nxt = cache_valid ? INIT : KEYGEN;
            KEYGEN:  if (rnd == 4'd10) fsm_nxt = INIT;
            INIT:    fsm_nxt = ROUND;
            ROUND:   if (rnd == 4'd1) fsm_nxt = FINAL;
            FINAL:   fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
        if (clr) fsm_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!g_rst_n) begin
            state       <= '0;
            plain_out   <= '0;
            done        <= 1'b0;
            cache_valid <= 1'b0;
            rnd         <= '0;
            for (int i = 1; i <= 10; i++) rk_reg[i] <= '0;
        end else begin
            done <= 1'b0;
            if (clr) plain_out <= '0;
            else case (fsm)
                IDLE: if (start) begin
                    state <= cipher_in;
                    rnd   <= 4'd1;
                end
                KEYGEN: begin
                    rk_reg[rnd] <= key_nxt;
                    rnd         <= rnd + 4'd1;
                    if (rnd == 4'd10) cache_valid <= 1'b1;
                end
                INIT: begin
                    state <= state ^ rk[10];
                    rnd   <= 4'd9;
                end
                ROUND: begin
                    state <= round_out;
                    rnd   <= rnd - 4'd1;
                end
                FINAL: begin
                    plain_out <= final_out;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
